rgb555_frame_reader: RTL

Display-side reader for the frame buffer holding the running frame averages, packed as {x,R5,G5,B5}.
- Prefetches packed words from frame-buffer memory in raster order through a request/acknowledge read port.
- Buffers them in a small FIFO and unpacks each to 10-bit-per-channel RGB for the VGA controller on pixel request.
- Sits between the frame-buffer arbiter and the VGA timing generator.

---
 rtl/rgb555_frame_reader_pkg.sv | 32 +++
 rtl/rgb555_frame_reader_sync_fifo.sv | 63 ++++++
 rtl/rgb555_frame_reader.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/rgb555_frame_reader_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rgb555_frame_reader_pkg
// Brief    : Packed RGB555 pixel layout and reader state encoding, shared with
//            the averager and the camera writer.
// Revision : 1.0 - initial release
// ============================================================================
package rgb555_frame_reader_pkg;

    localparam int PIX_R_MSB = 14;
    localparam int PIX_R_LSB = 10;
    localparam int PIX_G_MSB = 9;
    localparam int PIX_G_LSB = 5;
    localparam int PIX_B_MSB = 4;
    localparam int PIX_B_LSB = 0;
    localparam int CH_IN_W   = 5;
    localparam int CH_OUT_W  = 10;
    localparam int PIX_W     = PIX_R_MSB + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DONE  = 2'd2
    } readerState_t;

    // Bit replication keeps full-scale inputs at full scale (1F -> 3FF).
    function automatic logic [CH_OUT_W-1:0] expandChannel(input logic [CH_IN_W-1:0] ch);
        return {ch, ch};
    endfunction

endpackage
`default_nettype wire

// File: rtl/rgb555_frame_reader_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : rgb555_frame_reader_sync_fifo
// Brief    : Single-clock FIFO with flush and occupancy count; read data is the
//            head entry (no write-to-read bypass).
// Revision : 1.0 - initial release
// ============================================================================
module rgb555_frame_reader_sync_fifo #(
    parameter int WIDTH = 15,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_flush,
    input  logic                       i_wr,
    input  logic [WIDTH-1:0]           i_wrData,
    input  logic                       i_rd,
    output logic [WIDTH-1:0]           o_rdData,
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wrPtr;
    logic [PTR_W-1:0] r_rdPtr;
    logic [CNT_W-1:0] r_count;
    logic             w_rdEn;

    assign w_rdEn   = i_rd && (r_count != '0);
    assign o_rdData = r_mem[r_rdPtr];
    assign o_count  = r_count;

    always_ff @(posedge clk) begin
        if (i_wr && !i_flush) begin
            r_mem[r_wrPtr] <= i_wrData;
        end
    end

    // Depth is a power of two, so the pointers wrap on their own.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (i_wr) begin
                r_wrPtr <= r_wrPtr + PTR_W'(1);
            end
            if (w_rdEn) begin
                r_rdPtr <= r_rdPtr + PTR_W'(1);
            end
            r_count <= r_count + CNT_W'(i_wr) - CNT_W'(w_rdEn);
        end
    end

endmodule
`default_nettype wire

// File: rtl/rgb555_frame_reader.sv
`default_nettype none
// ============================================================================
// Module   : rgb555_frame_reader
// Brief    : Raster-order frame-buffer prefetcher that unpacks RGB555 words to
//            10-bit RGB for the VGA controller.
// Revision : 1.0 - initial release
// ============================================================================
module rgb555_frame_reader
    import rgb555_frame_reader_pkg::*;
#(
    parameter int H_ACTIVE   = 640,
    parameter int V_ACTIVE   = 480,
    parameter int FIFO_DEPTH = 8,
    parameter int ADDR_W     = 19
) (
    input  logic                iCLK,
    input  logic                iRST,
    input  logic                iFrameStart,
    output logic                oRdReq,
    output logic [ADDR_W-1:0]   oRdAddr,
    input  logic                iRdAck,
    input  logic                iRdValid,
    input  logic [15:0]         iRdData,
    input  logic                iPixReq,
    output logic [CH_OUT_W-1:0] oRed,
    output logic [CH_OUT_W-1:0] oGreen,
    output logic [CH_OUT_W-1:0] oBlue,
    output logic                oUnderflow,
    input  logic                iClrErr
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int SUM_W = CNT_W + 1;
    localparam logic [ADDR_W-1:0] c_lastAddr = ADDR_W'(H_ACTIVE * V_ACTIVE - 1);

    readerState_t      r_state;
    readerState_t      w_nextState;
    logic [ADDR_W-1:0] r_addr;
    logic [CNT_W-1:0]  r_outstanding;
    logic [CNT_W-1:0]  r_discard;
    logic [CNT_W-1:0]  w_fifoCount;
    logic [PIX_W-1:0]  w_fifoData;
    logic [SUM_W-1:0]  w_used;
    logic              w_credit;
    logic              w_ack;
    logic              w_validLive;
    logic              w_drop;
    logic              w_fifoWr;
    logic              w_fifoRd;
    logic              w_fifoEmpty;
    logic              w_unusedBit;

    assign w_unusedBit = iRdData[15];

    // Words still owed by memory, kept or not, all consume FIFO credit.
    assign w_used      = SUM_W'(w_fifoCount) + SUM_W'(r_outstanding) + SUM_W'(r_discard);
    assign w_credit    = w_used < SUM_W'(FIFO_DEPTH);
    assign w_ack       = oRdReq && iRdAck;
    assign w_validLive = iRdValid && ((r_discard != '0) || (r_outstanding != '0));
    assign w_drop      = iRdValid && (r_discard != '0);
    assign w_fifoWr    = w_validLive && !w_drop && !iFrameStart;
    assign w_fifoEmpty = (w_fifoCount == '0);
    assign w_fifoRd    = iPixReq && !w_fifoEmpty && !iFrameStart;
    assign oRdAddr     = r_addr;

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        oRdReq      = 1'b0;
        case (r_state)
            ST_IDLE: ;
            ST_FETCH: begin
                oRdReq = w_credit;
                if (w_credit && iRdAck && (r_addr == c_lastAddr)) begin
                    w_nextState = ST_DONE;
                end
            end
            ST_DONE: ;
            default: w_nextState = ST_IDLE;
        endcase
        if (iFrameStart) begin
            w_nextState = ST_FETCH;
        end
    end

    // On restart everything still in flight becomes discard credit.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            r_addr        <= '0;
            r_outstanding <= '0;
            r_discard     <= '0;
        end else if (iFrameStart) begin
            r_addr        <= '0;
            r_outstanding <= '0;
            r_discard     <= r_discard + r_outstanding + CNT_W'(w_ack) - CNT_W'(w_validLive);
        end else begin
            if (w_ack && (r_addr != c_lastAddr)) begin
                r_addr <= r_addr + ADDR_W'(1);
            end
            if (w_drop) begin
                r_discard <= r_discard - CNT_W'(1);
            end
            r_outstanding <= r_outstanding + CNT_W'(w_ack) - CNT_W'(w_fifoWr);
        end
    end

    rgb555_frame_reader_sync_fifo #(
        .WIDTH (PIX_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (iCLK),
        .rst      (iRST),
        .i_flush  (iFrameStart),
        .i_wr     (w_fifoWr),
        .i_wrData (iRdData[PIX_W-1:0]),
        .i_rd     (w_fifoRd),
        .o_rdData (w_fifoData),
        .o_count  (w_fifoCount)
    );

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            oRed   <= '0;
            oGreen <= '0;
            oBlue  <= '0;
        end else if (iPixReq && w_fifoEmpty) begin
            oRed   <= '0;
            oGreen <= '0;
            oBlue  <= '0;
        end else if (w_fifoRd) begin
            oRed   <= expandChannel(w_fifoData[PIX_R_MSB:PIX_R_LSB]);
            oGreen <= expandChannel(w_fifoData[PIX_G_MSB:PIX_G_LSB]);
            oBlue  <= expandChannel(w_fifoData[PIX_B_MSB:PIX_B_LSB]);
        end
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            oUnderflow <= 1'b0;
        end else if (iPixReq && w_fifoEmpty) begin
            oUnderflow <= 1'b1;
        end else if (iClrErr) begin
            oUnderflow <= 1'b0;
        end
    end

endmodule
`default_nettype wire
